// File: rtl/instr_mem_loader.sv
// Program loader: streams a 16-bit BE word count plus 32-bit BE words into the instruction-memory write port.
// Latency: 2 + 5*N cycles from LEN_HI entry to FIN, plus 1 cycle in FIN; wr_en one cycle after each 4th byte.
// Backpressure: in_ready high only in LEN_HI/LEN_LO/DATA; with in_valid low the FSM waits indefinitely.
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, FIN} state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] count;
  logic [15:0] k;
  logic [1:0]  b;
  // Only the first three bytes of a word need storing; the fourth goes
  // straight into wr_data on its handshake.
  logic [23:0] word;
  logic        hs;
  logic        room;
  logic [15:0] len_full;

  assign hs       = in_valid && in_ready;
  assign room     = ({16'd0, k} < MAX_W);
  assign len_full = {count[15:8], in_data};

  // State register; reset mid-load drops straight back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the state-derived strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    cpu_hold  = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (hs) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (hs) state_nxt = (len_full == 16'd0) ? FIN : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (hs && b == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en     = room;
        state_nxt = ((k + 16'd1) == count) ? FIN : DATA;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: count capture, byte assembly, write address/data, load statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= 16'd0;
      k            <= 16'd0;
      b            <= 2'd0;
      word         <= 24'd0;
      wr_addr      <= 32'd0;
      wr_data      <= 32'd0;
      overflow     <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            overflow     <= 1'b0;
            words_loaded <= 16'd0;
            k            <= 16'd0;
            b            <= 2'd0;
          end
        end
        LEN_HI: begin
          if (hs) count[15:8] <= in_data;
        end
        LEN_LO: begin
          if (hs) begin
            count[7:0] <= in_data;
            if ({16'd0, len_full} > MAX_W) overflow <= 1'b1;
          end
        end
        DATA: begin
          if (hs) begin
            word <= {word[15:0], in_data};
            b    <= b + 2'd1;
            // Address/data only move for words that will really be written,
            // so they hold the last written values otherwise.
            if (b == 2'd3 && room) begin
              wr_data <= {word, in_data};
              wr_addr <= BASE_ADDR + {14'd0, k, 2'b00};
            end
          end
        end
        WRITE: begin
          if (room) words_loaded <= words_loaded + 16'd1;
          k <= k + 16'd1;
          b <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: two instances (MAX_WORDS 64 and 2) share one input stream.
// Expected writes, counts, overflow and latency come from a per-load model built from the load contents.
// Stream bytes are offered with always-on, alternating or random in_valid.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready_a, wr_en_a, cpu_hold_a, done_a, overflow_a;
  logic [31:0] wr_addr_a, wr_data_a;
  logic [15:0] words_loaded_a;
  logic        in_ready_b, wr_en_b, cpu_hold_b, done_b, overflow_b;
  logic [31:0] wr_addr_b, wr_data_b;
  logic [15:0] words_loaded_b;

  always #5 clk = ~clk;

  instr_mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .cpu_hold(cpu_hold_a), .done(done_a), .overflow(overflow_a), .words_loaded(words_loaded_a)
  );

  instr_mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .cpu_hold(cpu_hold_b), .done(done_b), .overflow(overflow_b), .words_loaded(words_loaded_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, only appends/counts.
  logic [63:0] got_a[$];
  logic [63:0] got_b[$];
  int done_tot_a = 0;
  int done_tot_b = 0;
  int rise_cyc   = 0;
  int done_cyc   = 0;
  logic hold_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_en_a) got_a.push_back({wr_addr_a, wr_data_a});
    if (wr_en_b) got_b.push_back({wr_addr_b, wr_data_b});
    if (done_a) begin done_tot_a = done_tot_a + 1; done_cyc = cyc; end
    if (done_b) done_tot_b = done_tot_b + 1;
    if (cpu_hold_a && !hold_prev) rise_cyc = cyc;
    hold_prev = cpu_hold_a;
  end

  logic [7:0]  stream[$];
  logic [31:0] words[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_stream(input int cnt);
    logic [15:0] c16;
    c16 = 16'(cnt);
    stream.delete();
    stream.push_back(c16[15:8]);
    stream.push_back(c16[7:0]);
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] w;
      w = words[i];
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
  endtask

  // Feeds the stream (start pulsed on the first cycle) until every byte is taken.
  task automatic drive(input int mode);
    int  c;
    logic rdy;
    c = 0;
    start = 1'b1;
    while (stream.size() > 0 && c < 2000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (c % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = stream[0];
      @(negedge clk);
      rdy = in_ready_a;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (in_valid && rdy) void'(stream.pop_front());
      c++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("stream_consumed", 64'(stream.size()), 64'd0);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((cpu_hold_a || cpu_hold_b) && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("idle_reached", 64'(c < 100), 64'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic int min_i(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic check_side(input string tag, input int cnt, input int maxw, input int q0,
                            input int d0, input int dtot, input int wl, input logic ov);
    int n;
    n = min_i(cnt, maxw);
    for (int i = 0; i < n; i++) begin
      logic [63:0] obs;
      obs = (maxw == 64) ? ((q0 + i < got_a.size()) ? got_a[q0 + i] : 64'hx)
                         : ((q0 + i < got_b.size()) ? got_b[q0 + i] : 64'hx);
      chk({tag, "_write"}, obs, {32'(4 * i), words[i]});
    end
    chk({tag, "_nwrites"}, 64'((maxw == 64) ? got_a.size() - q0 : got_b.size() - q0), 64'(n));
    chk({tag, "_words_loaded"}, 64'(wl), 64'(n));
    chk({tag, "_overflow"}, 64'(ov), 64'(cnt > maxw));
    chk({tag, "_done_pulses"}, 64'(dtot - d0), 64'd1);
  endtask

  task automatic run_load(input string tag, input int cnt, input int mode);
    int qa0, qb0, da0, db0;
    qa0 = got_a.size();
    qb0 = got_b.size();
    da0 = done_tot_a;
    db0 = done_tot_b;
    make_stream(cnt);
    drive(mode);
    wait_idle();
    check_side({tag, "_a"}, cnt, 64, qa0, da0, done_tot_a, int'(words_loaded_a), overflow_a);
    check_side({tag, "_b"}, cnt, 2, qb0, db0, done_tot_b, int'(words_loaded_b), overflow_b);
    if (mode == 0) chk({tag, "_latency"}, 64'(done_cyc - rise_cyc), 64'(2 + 5 * cnt));
    chk({tag, "_hold_after"}, 64'(cpu_hold_a), 64'd0);
    chk({tag, "_ready_after"}, 64'(in_ready_a), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready_a), 64'd0);
    chk({tag, "_wr_en"}, 64'(wr_en_a), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr_a), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data_a), 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold_a), 64'd0);
    chk({tag, "_done"}, 64'(done_a), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow_a), 64'd0);
    chk({tag, "_overflow_b"}, 64'(overflow_b), 64'd0);
    chk({tag, "_words_loaded"}, 64'(words_loaded_a), 64'd0);
  endtask

  initial begin
    int qa0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset_vals("idle");
    in_valid = 1'b0;

    // Two-word program, in_valid always high.
    words.delete();
    words.push_back(32'h0022_1820);
    words.push_back(32'h0064_2822);
    run_load("cnt2", 2, 0);

    // Same program with in_valid alternating.
    run_load("cnt2_toggle", 2, 1);

    // Empty program.
    words.delete();
    run_load("cnt0", 0, 0);

    // Three words: overflows the 2-word instance only.
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    run_load("cnt3", 3, 0);

    // Abort after the second data byte, then reload one word.
    words.delete();
    words.push_back(32'hDEAD_BEEF);
    qa0 = got_a.size();
    make_stream(1);
    void'(stream.pop_back());
    void'(stream.pop_back());
    drive(0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_vals("abort");
    chk("abort_no_write", 64'(got_a.size() - qa0), 64'd0);
    words.delete();
    words.push_back(32'h012A_4020);
    run_load("after_abort", 1, 0);

    // Random programs with random in_valid.
    for (int t = 0; t < 4; t++) begin
      int cnt;
      cnt = $urandom_range(1, 5);
      words.delete();
      for (int i = 0; i < cnt; i++) words.push_back($urandom);
      run_load($sformatf("rand%0d", t), cnt, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
